modulation_multiplier: RTL and testbench

- Downstream consumer of the modulation swapchain's SEGMENT/STOP/IDX outputs.
- Fetches the current modulation sample from modulation BRAM and latches one sample per transducer frame.
- Scales the per-transducer intensity stream by that sample and forwards phase unchanged with matching latency.
- Sits between the STM/gain stream source and the PWM stage.

---
 rtl/modulation_multiplier_if.sv | 28 ++
 rtl/modulation_multiplier.sv | 108 ++++++++++
 tb/tb_modulation_multiplier.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/modulation_multiplier_if.sv
// Stream, control and BRAM signals of the modulation multiplier.
// The slave modport is the multiplier side; master is the producer/BRAM side.
interface modulation_multiplier_if #(
    parameter int NumSegment = 2
);
    logic                             segment;
    logic                             stop;
    logic [NumSegment-1:0][14:0]      idx;
    logic [15:0]                      mem_addr;
    logic [7:0]                       mem_data;
    logic                             din_valid;
    logic [7:0]                       intensity_in;
    logic [7:0]                       phase_in;
    logic                             dout_valid;
    logic [7:0]                       intensity_out;
    logic [7:0]                       phase_out;
    logic [7:0]                       mod_out;

    modport slave (
        input  segment, stop, idx, mem_data, din_valid, intensity_in, phase_in,
        output mem_addr, dout_valid, intensity_out, phase_out, mod_out
    );

    modport master (
        output segment, stop, idx, mem_data, din_valid, intensity_in, phase_in,
        input  mem_addr, dout_valid, intensity_out, phase_out, mod_out
    );
endinterface

// File: rtl/modulation_multiplier.sv
// Fetches the active modulation sample from BRAM, latches it once per frame and
// scales the intensity stream by (mod+1)/256 through a fixed 3-stage pipeline.
module modulation_multiplier #(
    parameter int NumTransducers = 249,
    parameter int MemLatency     = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    modulation_multiplier_if.slave  bus
);
    localparam int CntW = $clog2(NumTransducers);

    logic [MemLatency:0] issue_sr;
    logic [7:0]          mod_cur;
    logic [7:0]          mod_frame;
    logic [CntW-1:0]     cnt;
    logic [7:0]          mod_sel;

    logic                v1, v2;
    logic [7:0]          int1, ph1, mod1, ph2, mod2;
    logic [16:0]         prod2;
    logic [8:0]          mod_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_addr <= '0;
        end else if (!bus.stop) begin
            bus.mem_addr <= {bus.segment, bus.idx[bus.segment]};
        end
    end

    // Bit 0 accompanies MEM_ADDR; bit MemLatency lines up with its MEM_DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_sr <= '0;
            mod_cur  <= '0;
        end else begin
            issue_sr <= {issue_sr[MemLatency-1:0], !bus.stop};
            if (issue_sr[MemLatency]) begin
                mod_cur <= bus.mem_data;
            end
        end
    end

    always_comb begin
        mod_sel = mod_frame;
        if (cnt == '0) begin
            mod_sel = mod_cur;
        end
        mod_p1 = {1'b0, mod1} + 9'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mod_frame <= '0;
            v1        <= 1'b0;
            int1      <= '0;
            ph1       <= '0;
            mod1      <= '0;
        end else begin
            v1 <= bus.din_valid;
            if (bus.din_valid) begin
                int1 <= bus.intensity_in;
                ph1  <= bus.phase_in;
                mod1 <= mod_sel;
                if (cnt == '0) begin
                    mod_frame <= mod_cur;
                end
                if (cnt == CntW'(NumTransducers - 1)) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            prod2 <= '0;
            ph2   <= '0;
            mod2  <= '0;
        end else begin
            v2    <= v1;
            prod2 <= 17'(int1) * 17'(mod_p1);
            ph2   <= ph1;
            mod2  <= mod1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout_valid    <= 1'b0;
            bus.intensity_out <= '0;
            bus.phase_out     <= '0;
            bus.mod_out       <= '0;
        end else begin
            bus.dout_valid <= v2;
            if (v2) begin
                bus.intensity_out <= 8'(prod2 >> 8);
                bus.phase_out     <= ph2;
                bus.mod_out       <= mod2;
            end
        end
    end
endmodule

// File: tb/tb_modulation_multiplier.sv
// Directed bench for modulation_multiplier: a frame-level behavioural model
// checked every cycle, plus hand-computed literal expectations.
module tb_modulation_multiplier;
    localparam int NT  = 249;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    modulation_multiplier_if #(.NumSegment(2)) bus ();

    modulation_multiplier #(
        .NumTransducers(NT),
        .MemLatency(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] bram [65536];
    logic [7:0] mem_pipe [LAT];
    assign bus.mem_data = mem_pipe[LAT-1];

    always @(posedge clk) begin
        mem_pipe[0] <= bram[bus.mem_addr];
        for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: fetch history -> current sample; frame counter picks the sample for each beat.
    int m_cur = 0, m_frame = 0, m_cnt = 0, m_addr = 0;
    int h_v [LAT+1];
    int h_a [LAT+1];
    int p_v [3], p_i [3], p_p [3], p_m [3];
    int e_v = 0, e_int = 0, e_ph = 0, e_mod = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cur = 0; m_frame = 0; m_cnt = 0; m_addr = 0;
                for (int i = 0; i <= LAT; i++) begin h_v[i] = 0; h_a[i] = 0; end
                for (int i = 0; i < 3; i++) begin p_v[i] = 0; p_i[i] = 0; p_p[i] = 0; p_m[i] = 0; end
                e_v = 0; e_int = 0; e_ph = 0; e_mod = 0;
            end else begin
                int use_mod;
                use_mod = m_frame;
                if (bus.din_valid) begin
                    if (m_cnt == 0) begin
                        use_mod = m_cur;
                        m_frame = m_cur;
                    end
                    m_cnt = (m_cnt + 1) % NT;
                end
                for (int i = 2; i > 0; i--) begin
                    p_v[i] = p_v[i-1]; p_i[i] = p_i[i-1]; p_p[i] = p_p[i-1]; p_m[i] = p_m[i-1];
                end
                p_v[0] = int'(bus.din_valid);
                p_i[0] = (int'(bus.intensity_in) * (use_mod + 1)) / 256;
                p_p[0] = int'(bus.phase_in);
                p_m[0] = use_mod;
                e_v = p_v[2];
                if (p_v[2] != 0) begin
                    e_int = p_i[2]; e_ph = p_p[2]; e_mod = p_m[2];
                end
                if (h_v[LAT] != 0) m_cur = int'(bram[h_a[LAT]]);
                for (int i = LAT; i > 0; i--) begin h_v[i] = h_v[i-1]; h_a[i] = h_a[i-1]; end
                h_v[0] = int'(!bus.stop);
                h_a[0] = int'({bus.segment, bus.idx[bus.segment]});
                if (!bus.stop) m_addr = h_a[0];
            end
        end
    end

    int last_int = -1, last_mod = -1;
    int din_first = -1, dout_first = -1;

    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 2) begin
                check("dout_valid", int'(bus.dout_valid), e_v);
                check("mem_addr", int'(bus.mem_addr), m_addr);
                check("mod_out", int'(bus.mod_out), e_mod);
                if (e_v != 0) begin
                    check("intensity_out", int'(bus.intensity_out), e_int);
                    check("phase_out", int'(bus.phase_out), e_ph);
                end
                if (bus.dout_valid) begin
                    last_int = int'(bus.intensity_out);
                    last_mod = int'(bus.mod_out);
                    if (din_first >= 0 && dout_first < 0) dout_first = cyc;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic beat(input int inten, input int ph);
        bus.din_valid    = 1'b1;
        bus.intensity_in = 8'(inten);
        bus.phase_in     = 8'(ph);
        if (din_first < 0) din_first = cyc;
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic beats(input int n, input int inten, input int gap);
        for (int i = 0; i < n; i++) begin
            beat(inten, (i * 7) & 255);
            if (gap != 0) idle(1);
        end
    endtask

    task automatic expect_last(input string name, input int exp_int, input int exp_mod);
        idle(4);
        check({name, "_int"}, last_int, exp_int);
        check({name, "_mod"}, last_mod, exp_mod);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) bram[i] = 8'd0;
        for (int i = 0; i < LAT; i++) mem_pipe[i] = 8'd0;
        bram[16'h0005] = 8'd128;
        bram[16'h0006] = 8'd64;
        bram[16'h0001] = 8'd255;
        bram[16'h0002] = 8'd0;
        bram[16'h0003] = 8'd1;
        bram[16'h000A] = 8'd200;
        bram[16'h000B] = 8'd100;
        bram[16'h000C] = 8'd50;
        bram[16'h0007] = 8'd255;
        bram[16'h8007] = 8'd32;

        bus.segment = 1'b0; bus.stop = 1'b0;
        bus.idx[0] = 15'd5; bus.idx[1] = 15'd0;
        bus.din_valid = 1'b0; bus.intensity_in = '0; bus.phase_in = '0;

        idle(3);
        check("rst_mem_addr", int'(bus.mem_addr), 0);
        check("rst_dout_valid", int'(bus.dout_valid), 0);
        check("rst_intensity", int'(bus.intensity_out), 0);
        check("rst_phase", int'(bus.phase_out), 0);
        check("rst_mod_out", int'(bus.mod_out), 0);
        rst_n = 1'b1;
        idle(10);

        // Basic frame: 200 * 129 >> 8 = 100.
        beats(NT, 200, 0);
        expect_last("basic", 100, 128);
        check("first_latency", dout_first - din_first, 3);

        // Boundary modulation values at full intensity.
        bus.idx[0] = 15'd1; idle(10); beats(NT, 255, 0); expect_last("mod255", 255, 255);
        bus.idx[0] = 15'd2; idle(10); beats(NT, 255, 0); expect_last("mod0", 0, 0);
        bus.idx[0] = 15'd3; idle(10); beats(NT, 255, 0); expect_last("mod1", 1, 1);

        // Mid-frame sample change applies from the next frame: 200*65>>8 = 50.
        bus.idx[0] = 15'd5; idle(10);
        beats(100, 200, 0);
        bus.idx[0] = 15'd6;
        beats(NT - 100, 200, 0);
        expect_last("midframe_old", 100, 128);
        beats(NT, 200, 0);
        expect_last("midframe_new", 50, 64);

        // STOP freezes the sample while IDX walks; release picks up 50: 200*51>>8 = 39.
        bus.idx[0] = 15'd5; idle(10);
        bus.stop = 1'b1;
        bus.idx[0] = 15'd10; idle(3);
        bus.idx[0] = 15'd11; idle(3);
        bus.idx[0] = 15'd12; idle(3);
        beats(NT, 200, 0);
        expect_last("stop_frozen", 100, 128);
        bus.stop = 1'b0;
        idle(6);
        beats(NT, 200, 0);
        expect_last("stop_release", 39, 50);

        // Segment switch: 255*33>>8 = 32.
        bus.idx[0] = 15'd7; bus.idx[1] = 15'd7; idle(6);
        bus.segment = 1'b1;
        idle(1);
        check("seg_addr_msb", int'(bus.mem_addr[15]), 1);
        idle(6);
        beats(NT, 255, 0);
        expect_last("segment", 32, 32);

        // Gapped stream with a reset pulse at beat 120.
        beats(120, 100, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_dout_valid", int'(bus.dout_valid), 0);
        check("midrst_intensity", int'(bus.intensity_out), 0);
        check("midrst_mod_out", int'(bus.mod_out), 0);
        check("midrst_mem_addr", int'(bus.mem_addr), 0);
        idle(2);
        rst_n = 1'b1;
        idle(6);
        beats(200, 100, 1);
        bus.segment = 1'b0;
        beats(NT - 200, 100, 1);
        expect_last("gapped_frame", 12, 32);
        beats(1, 100, 1);
        expect_last("gapped_next", 100, 255);

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
